// File: rtl/acc_requant.sv
// Accumulator requantiser: multiply, rounding right shift, zero-point offset
// and output clamp, in a backpressured pipeline with a saturation counter.
module acc_requant #(
   parameter int ACC_W  = 32,
   parameter int MULT_W = 16,
   parameter int OUT_W  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cfg_we,
   input  logic signed [MULT_W-1:0] cfg_mult,
   input  logic [4:0]               cfg_shift,
   input  logic signed [OUT_W-1:0]  cfg_zp,
   output logic                     cfg_busy,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [ACC_W-1:0]  in_acc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  out_data,
   output logic [15:0]              sat_count
);

   localparam int P_W    = ACC_W + MULT_W;
   localparam int R_W    = P_W + 1;
   localparam int V_W    = P_W + 2;
   localparam int STAGES = 3;
   localparam logic signed [V_W-1:0] OMAX = (V_W'(1) << (OUT_W - 1)) - V_W'(1);
   localparam logic signed [V_W-1:0] OMIN = ~OMAX;

   // vld_pipe_q[0]: operand reg of S1, [1]: S2, [2]: S3, [3]: registered output
   logic [STAGES:0]          vld_pipe_q, vld_pipe_d;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [P_W-1:0]    prod_q, prod_d;
   logic signed [R_W-1:0]    rnd_q, rnd_d;
   logic signed [OUT_W-1:0]  out_data_q, out_data_d;
   logic                     sat_q, sat_d;
   logic [15:0]              sat_cnt_q, sat_cnt_d;
   logic signed [MULT_W-1:0] mult_q;
   logic [4:0]               shift_q;
   logic signed [OUT_W-1:0]  zp_q;

   logic                     adv, cfg_ld;
   logic signed [P_W-1:0]    a_ext, m_ext;
   logic signed [R_W-1:0]    p_ext, bias, sum;
   logic signed [V_W-1:0]    r_ext, zp_ext, v;

   always_comb begin
      adv        = !vld_pipe_q[STAGES] || out_ready;
      cfg_ld     = cfg_we && !cfg_busy && !in_valid;
      vld_pipe_d = {vld_pipe_q[STAGES-1:0], in_valid};

      // S1: full-width signed product
      a_ext  = {{MULT_W{acc_q[ACC_W-1]}}, acc_q};
      m_ext  = {{ACC_W{mult_q[MULT_W-1]}}, mult_q};
      prod_d = a_ext * m_ext;

      // S2: add half an LSB then arithmetic shift; one guard bit keeps the add exact
      p_ext = {prod_q[P_W-1], prod_q};
      bias  = (shift_q == 5'd0) ? '0 : (R_W'(1) << (shift_q - 5'd1));
      sum   = p_ext + bias;
      rnd_d = sum >>> shift_q;

      // S3: zero-point offset and clamp
      r_ext  = {rnd_q[R_W-1], rnd_q};
      zp_ext = {{(V_W-OUT_W){zp_q[OUT_W-1]}}, zp_q};
      v      = r_ext + zp_ext;
      sat_d  = (v > OMAX) || (v < OMIN);
      if (v > OMAX)      out_data_d = OMAX[OUT_W-1:0];
      else if (v < OMIN) out_data_d = OMIN[OUT_W-1:0];
      else               out_data_d = v[OUT_W-1:0];

      sat_cnt_d = sat_cnt_q;
      if (cfg_ld)
         sat_cnt_d = '0;
      else if (vld_pipe_q[STAGES] && out_ready && sat_q && sat_cnt_q != 16'hFFFF)
         sat_cnt_d = sat_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe_q <= '0;
         acc_q      <= '0;
         prod_q     <= '0;
         rnd_q      <= '0;
         out_data_q <= '0;
         sat_q      <= 1'b0;
         sat_cnt_q  <= '0;
         mult_q     <= MULT_W'(1);
         shift_q    <= '0;
         zp_q       <= '0;
      end else begin
         sat_cnt_q <= sat_cnt_d;
         if (cfg_ld) begin
            mult_q  <= cfg_mult;
            shift_q <= cfg_shift;
            zp_q    <= cfg_zp;
         end
         if (adv) begin
            vld_pipe_q <= vld_pipe_d;
            acc_q      <= in_acc;
            prod_q     <= prod_d;
            rnd_q      <= rnd_d;
            out_data_q <= out_data_d;
            sat_q      <= sat_d;
         end
      end
   end

   assign in_ready  = adv;
   assign cfg_busy  = |vld_pipe_q;
   assign out_valid = vld_pipe_q[STAGES];
   assign out_data  = out_data_q;
   assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_acc_requant.sv
// Directed bench for acc_requant: vector table with hand-computed results,
// plus sequences for backpressure, config gating and mid-flight reset.
module tb_acc_requant;

   logic               clk = 1'b0;
   logic               reset;
   logic               cfg_we;
   logic signed [15:0] cfg_mult;
   logic [4:0]         cfg_shift;
   logic signed [7:0]  cfg_zp;
   logic               cfg_busy;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] in_acc;
   logic               out_valid;
   logic               out_ready;
   logic signed [7:0]  out_data;
   logic [15:0]        sat_count;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   acc_requant #(.ACC_W(32), .MULT_W(16), .OUT_W(8)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_mult(cfg_mult),
      .cfg_shift(cfg_shift), .cfg_zp(cfg_zp), .cfg_busy(cfg_busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sat_count(sat_count)
   );

   typedef struct {
      logic signed [31:0] acc;
      logic signed [15:0] mult;
      logic [4:0]         sh;
      logic signed [7:0]  zp;
      logic signed [7:0]  exp;
      bit                 sat;
   } vec_t;

   localparam int NV = 20;
   vec_t tbl [NV];

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic cfg_write(input logic signed [15:0] m, input logic [4:0] s, input logic signed [7:0] z);
      @(negedge clk);
      cfg_we = 1'b1; cfg_mult = m; cfg_shift = s; cfg_zp = z;
      @(posedge clk);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic send(input logic signed [31:0] a);
      @(negedge clk);
      in_valid = 1'b1; in_acc = a;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Called at the negedge after the accept edge; consumes the item.
   task automatic wait_out(output logic signed [7:0] d, output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      d = out_data;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic signed [15:0] cm;
      logic [4:0]         cs;
      logic signed [7:0]  cz;
      logic signed [7:0]  d;
      int                 lat;
      int                 msat;

      tbl = '{
         '{ 32'sd100,       16'sd1,     5'd0,  8'sd0,    8'sd100,  1'b0},
         '{-32'sd100,       16'sd1,     5'd0,  8'sd0,   -8'sd100,  1'b0},
         '{ 32'sd200,       16'sd1,     5'd0,  8'sd0,    8'sd127,  1'b1},
         '{-32'sd300,       16'sd1,     5'd0,  8'sd0,    8'sh80,   1'b1},
         '{ 32'sd5,         16'sd3,     5'd2,  8'sd0,    8'sd4,    1'b0},
         '{-32'sd6,         16'sd1,     5'd2,  8'sd0,   -8'sd1,    1'b0},
         '{-32'sd2,         16'sd1,     5'd2,  8'sd0,    8'sd0,    1'b0},
         '{ 32'sd120,       16'sd1,     5'd0, -8'sd10,   8'sd110,  1'b0},
         '{-32'sd125,       16'sd1,     5'd0, -8'sd10,   8'sh80,   1'b1},
         '{ 32'sd0,         16'sd1,     5'd0,  8'sd127,  8'sd127,  1'b0},
         '{ 32'sd1,         16'sd1,     5'd0,  8'sd127,  8'sd127,  1'b1},
         '{ 32'sd0,         16'sd1,     5'd0,  8'sh80,   8'sh80,   1'b0},
         '{-32'sd1,         16'sd1,     5'd0,  8'sh80,   8'sh80,   1'b1},
         '{ 32'sh7fffffff,  16'sh7fff,  5'd31, 8'sd0,    8'sd127,  1'b1},
         '{ 32'sh80000000,  16'sh8000,  5'd31, 8'sd0,    8'sd127,  1'b1},
         '{ 32'sh80000000,  16'sh7fff,  5'd31, 8'sd0,    8'sh80,   1'b1},
         '{ 32'sh40000000,  16'sd1,     5'd31, 8'sd0,    8'sd1,    1'b0},
         '{ 32'shC0000000,  16'sd1,     5'd31, 8'sd0,    8'sd0,    1'b0},
         '{ 32'sd6,         16'sd1,     5'd2,  8'sd0,    8'sd2,    1'b0},
         '{-32'sd3,         16'sd1,     5'd1,  8'sd0,   -8'sd1,    1'b0}
      };

      reset = 1'b1; cfg_we = 1'b0; cfg_mult = '0; cfg_shift = '0; cfg_zp = '0;
      in_valid = 1'b0; in_acc = '0; out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_sat_count", sat_count, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_cfg_busy", cfg_busy, 0);

      // Vector table
      cm = 16'sd1; cs = 5'd0; cz = 8'sd0; msat = 0;
      for (int i = 0; i < NV; i++) begin
         if (tbl[i].mult !== cm || tbl[i].sh !== cs || tbl[i].zp !== cz) begin
            cfg_write(tbl[i].mult, tbl[i].sh, tbl[i].zp);
            cm = tbl[i].mult; cs = tbl[i].sh; cz = tbl[i].zp; msat = 0;
            chk($sformatf("v%0d_cfg_clr_sat", i), sat_count, 0);
         end
         send(tbl[i].acc);
         wait_out(d, lat);
         chk($sformatf("v%0d_data", i), d, tbl[i].exp);
         chk($sformatf("v%0d_latency", i), lat, 3);
         if (tbl[i].sat) msat++;
         chk($sformatf("v%0d_sat_count", i), sat_count, msat);
      end

      // Backpressure: stream 0..9, out_ready low for cycles 5..9
      cfg_write(16'sd1, 5'd0, 8'sd0);
      begin
         logic signed [7:0] rx [10];
         logic signed [7:0] prev;
         int  idx, got, cyc, stall_lo;
         bit  ir_bad, hold_bad, prev_stall;
         idx = 0; got = 0; cyc = 0; stall_lo = 0;
         ir_bad = 0; hold_bad = 0; prev_stall = 0; prev = '0;
         while (got < 10 && cyc < 100) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc < 10);
            in_valid  = (idx < 10);
            in_acc    = idx;
            #1;
            if (in_ready !== (!out_valid || out_ready)) ir_bad = 1;
            if (!out_ready && in_ready === 1'b0) stall_lo++;
            if (prev_stall && out_data !== prev) hold_bad = 1;
            if (out_valid && out_ready) begin rx[got] = out_data; got++; end
            if (in_valid && in_ready) idx++;
            prev_stall = out_valid && !out_ready;
            prev = out_data;
            @(posedge clk);
            cyc++;
         end
         @(negedge clk);
         in_valid = 1'b0; out_ready = 1'b1;
         chk("bp_count", got, 10);
         for (int k = 0; k < 10; k++)
            if (k < got) chk($sformatf("bp_item%0d", k), rx[k], k);
         chk("bp_in_ready_eq_adv", ir_bad, 0);
         chk("bp_in_ready_low_cycles", stall_lo, 5);
         chk("bp_hold_stable", hold_bad, 0);
      end

      // Config gating: ignored while busy, ignored while in_valid, count kept
      cfg_write(16'sd1, 5'd0, 8'sd0);
      send(32'sd200);
      wait_out(d, lat);
      chk("gate_sat_item", d, 127);
      chk("gate_sat_count", sat_count, 1);
      @(negedge clk);
      in_valid = 1'b1; in_acc = 32'sd50;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      cfg_we = 1'b1; cfg_mult = 16'sd2; cfg_shift = 5'd0; cfg_zp = 8'sd5;
      chk("gate_busy", cfg_busy, 1);
      @(posedge clk);
      @(negedge clk);
      cfg_we = 1'b0;
      wait_out(d, lat);
      chk("gate_busy_item", d, 50);
      send(32'sd7);
      wait_out(d, lat);
      chk("gate_after_busy", d, 7);
      @(negedge clk);
      cfg_we = 1'b1; cfg_mult = 16'sd2; in_valid = 1'b1; in_acc = 32'sd9;
      @(posedge clk);
      @(negedge clk);
      cfg_we = 1'b0; in_valid = 1'b0;
      wait_out(d, lat);
      chk("gate_invalid_item", d, 9);
      send(32'sd4);
      wait_out(d, lat);
      chk("gate_after_invalid", d, 4);
      chk("gate_sat_kept", sat_count, 1);
      chk("gate_idle_busy", cfg_busy, 0);

      // Reset with three items in flight, non-identity config loaded
      cfg_write(16'sd2, 5'd1, 8'sd3);
      @(negedge clk);
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_acc = 32'sd11 + k;
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("rst2_busy_before", cfg_busy, 1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst2_out_valid", out_valid, 0);
      chk("rst2_busy", cfg_busy, 0);
      chk("rst2_in_ready", in_ready, 1);
      chk("rst2_out_data", out_data, 0);
      begin
         bit stale;
         stale = 0;
         for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b0) stale = 1;
         end
         chk("rst2_no_stale", stale, 0);
      end
      send(32'sd100);
      wait_out(d, lat);
      chk("rst2_identity_pos", d, 100);
      send(-32'sd100);
      wait_out(d, lat);
      chk("rst2_identity_neg", d, -100);
      chk("rst2_sat_count", sat_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/acc_requant.md
ACC_REQUANT -- requirements
Module: acc_requant

Interface
REQ-001 Parameter ACC_W, default 32: signed accumulator input width.
REQ-002 Parameter MULT_W, default 16: signed requantisation multiplier width.
REQ-003 Parameter OUT_W, default 8: signed output width; feeds the ReLU clamp stage.
REQ-004 Port clk  input  1  single clock; all logic rising-edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port cfg_we  input  1  config write strobe.
REQ-007 Port cfg_mult  input  MULT_W  signed multiplier.
REQ-008 Port cfg_shift  input  5  right-shift amount, 0..31.
REQ-009 Port cfg_zp  input  OUT_W  signed zero-point offset.
REQ-010 Port cfg_busy  output  1  high when any pipeline stage holds valid data.
REQ-011 Port in_valid / in_ready  input / output  1 each  upstream handshake.
REQ-012 Port in_acc  input  ACC_W  signed accumulator value.
REQ-013 Port out_valid / out_ready  output / input  1 each  downstream handshake.
REQ-014 Port out_data  output  OUT_W  signed requantised result.
REQ-015 Port sat_count  output  16  count of saturated results.

Function
REQ-016 Transfer occurs on a rising edge with valid and ready both high; no other event accepts or emits data.
REQ-017 Three-stage pipeline S1 multiply, S2 round/shift, S3 offset/saturate, plus one valid bit per stage.
REQ-018 Global advance enable adv = !out_valid || out_ready; all stages shift only when adv is high.
REQ-019 in_ready SHALL equal adv combinationally; data is never dropped or duplicated under backpressure.
REQ-020 Latency: an item accepted at edge N appears on out_data/out_valid after edge N+3 when out_ready is held high.
REQ-021 Throughput: one item per cycle sustained while out_ready is high.
REQ-022 S1: prod = in_acc * cfg_mult, full 48-bit signed product (ACC_W+MULT_W).
REQ-023 S2: shift 0 gives r = prod; otherwise r = (prod + 2^(shift-1)) >>> shift, arithmetic, computed at 49 bits with no overflow (round half toward +inf).
REQ-024 S3: v = r + sign-extended cfg_zp at 50 bits, then clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-025 out_data, out_valid SHALL be registered outputs of S3 and held stable while out_valid && !out_ready.
REQ-026 sat_count increments by 1 when an item whose S3 clamp was active is transferred out; saturates at 0xFFFF, no wrap.
REQ-027 Config registers load from cfg_* on cfg_we only when cfg_busy is low and in_valid is low; otherwise cfg_we is ignored.
REQ-028 Accepted cfg_we clears sat_count to 0 on the same edge.
REQ-029 New configuration applies to items accepted on edges strictly after the loading edge.
REQ-030 cfg_busy = OR of S1, S2, S3 valid bits.

Reset
REQ-031 While reset is high at an edge: all stage valids, out_valid, sat_count cleared to 0.
REQ-032 Reset values: out_data 0, cfg_mult 1, cfg_shift 0, cfg_zp 0 (identity transform).
REQ-033 Reset mid-operation discards all in-flight items; no item accepted before reset is emitted after it.
REQ-034 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-035 Identity after reset: in_acc 100 then -100 -> out_data 100, -100 after 3 cycles each, sat_count 0.
REQ-036 Saturation: in_acc 200, then -300 -> out_data 127, -128; sat_count 2.
REQ-037 Rounding: cfg mult 3, shift 2, zp 0; in_acc 5 -> 4; in_acc -6 with mult 1 -> -1; in_acc -2 with mult 1 -> 0.
REQ-038 Zero point: mult 1, shift 0, zp -10; in_acc 120 -> 110; in_acc -125 -> -128 saturated, sat_count 1.
REQ-039 Backpressure: stream 0..9 with out_ready low for 5 cycles mid-stream -> in_ready low during stall, outputs 0..9 in order, none lost or repeated.
REQ-040 Config gating/reset: cfg_we while busy ignored (results unchanged); reset asserted with 3 items in flight -> out_valid 0, no stale output afterwards.
